up_down_counter: RTL and testbench

Programmable bounded up/down counter with an 8-bit bus-style register interface. A host writes start, upper-limit, lower-limit and cycle-count registers over a shared bidirectional data bus. After a `start` pulse the counter sweeps start→upper→lower→back to start for the programmed number of cycles, then flags end-of-count. It sits as a memory-mapped peripheral, with `cout` feeding downstream logic.

---
 rtl/up_down_counter_if.sv | 25 ++
 rtl/up_down_counter.sv | 148 ++++++++++++++
 tb/tb_up_down_counter.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/up_down_counter_if.sv
// Host-side register bus of the up/down counter: address, strobes, run
// request and the status/count outputs. The shared data bus stays a plain
// inout port on the counter so tristate resolution happens at a module boundary.
interface up_down_counter_if;
    logic       A0;
    logic       A1;
    logic       ncs;
    logic       nwr;
    logic       nrd;
    logic       start;
    logic       err;
    logic [7:0] cout;
    logic       dir;
    logic       ec;

    modport master (
        output A0, A1, ncs, nwr, nrd, start,
        input  err, cout, dir, ec
    );

    modport slave (
        input  A0, A1, ncs, nwr, nrd, start,
        output err, cout, dir, ec
    );
endinterface

// File: rtl/up_down_counter.sv
// Programmable bounded up/down counter. The host loads start (S), upper (U),
// lower (L) and cycle-count (C) registers over an 8-bit shared bus; a start
// pulse then sweeps S -> U -> L -> S for C cycles and raises ec at the end.
module up_down_counter (
    input  logic             clk,
    input  logic             rst,
    up_down_counter_if.slave bus,
    inout  wire  [7:0]       din
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t     state;
    logic [7:0] s_reg;
    logic [7:0] u_reg;
    logic [7:0] l_reg;
    logic [7:0] c_reg;
    logic [7:0] cyc_cnt;
    logic [7:0] cout_q;
    logic       dir_q;
    logic       ec_q;
    logic       err_q;
    // Set once the sweep has turned around at U in the current cycle; an
    // upward step only closes a cycle after that has happened.
    logic       down_seen;

    logic [1:0] addr;
    logic       wr_en;
    logic       rd_en;
    logic       cfg_ok;
    logic [7:0] rd_mux;

    logic [7:0] step_val;
    logic       step_dir;
    logic       step_down_seen;
    logic       at_bound;
    logic [7:0] cyc_next;

    assign addr   = {bus.A1, bus.A0};
    assign wr_en  = !bus.ncs && !bus.nwr &&  bus.nrd;
    assign rd_en  = !bus.ncs && !bus.nrd &&  bus.nwr;
    assign cfg_ok = (l_reg < s_reg) && (s_reg <= u_reg) && (c_reg != 8'd0);

    // Register read mux for the combinational bus read.
    always_comb begin
        rd_mux = s_reg;
        case (addr)
            2'b00:   rd_mux = s_reg;
            2'b01:   rd_mux = u_reg;
            2'b10:   rd_mux = l_reg;
            default: rd_mux = c_reg;
        endcase
    end

    assign din = rd_en ? rd_mux : 8'bz;

    // Next sweep position and whether it closes a cycle (back to S going up).
    always_comb begin
        step_val       = cout_q;
        step_dir       = dir_q;
        step_down_seen = down_seen;
        if (dir_q) begin
            if (cout_q < u_reg) begin
                step_val = cout_q + 8'd1;
            end else begin
                step_val       = u_reg - 8'd1;
                step_dir       = 1'b0;
                step_down_seen = 1'b1;
            end
        end else begin
            if (cout_q > l_reg) begin
                step_val = cout_q - 8'd1;
            end else begin
                step_val = l_reg + 8'd1;
                step_dir = 1'b1;
            end
        end
        at_bound = step_dir && step_down_seen && (step_val == s_reg);
        cyc_next = cyc_cnt + 8'd1;
    end

    // Control FSM, register file and counter: reset, then chip-deselect
    // abort, then start/write in IDLE or one sweep step per clock in RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            s_reg     <= 8'd0;
            u_reg     <= 8'd0;
            l_reg     <= 8'd0;
            c_reg     <= 8'd0;
            cyc_cnt   <= 8'd0;
            cout_q    <= 8'd0;
            dir_q     <= 1'b0;
            ec_q      <= 1'b0;
            err_q     <= 1'b0;
            down_seen <= 1'b0;
        end else if (bus.ncs) begin
            state  <= IDLE;
            cout_q <= 8'd0;
            ec_q   <= 1'b0;
            dir_q  <= 1'b0;
        end else if (state == IDLE) begin
            if (bus.start) begin
                if (cfg_ok) begin
                    cout_q    <= s_reg;
                    dir_q     <= 1'b1;
                    cyc_cnt   <= 8'd0;
                    down_seen <= 1'b0;
                    ec_q      <= 1'b0;
                    err_q     <= 1'b0;
                    state     <= RUN;
                end else begin
                    err_q <= 1'b1;
                end
            end else if (wr_en) begin
                case (addr)
                    2'b00:   s_reg <= din;
                    2'b01:   u_reg <= din;
                    2'b10:   l_reg <= din;
                    default: c_reg <= din;
                endcase
                ec_q  <= 1'b0;
                err_q <= 1'b0;
            end
        end else begin
            cout_q    <= step_val;
            dir_q     <= step_dir;
            down_seen <= step_down_seen;
            if (at_bound) begin
                cyc_cnt   <= cyc_next;
                down_seen <= 1'b0;
                if (cyc_next == c_reg) begin
                    ec_q  <= 1'b1;
                    state <= IDLE;
                end
            end
        end
    end

    assign bus.cout = cout_q;
    assign bus.dir  = dir_q;
    assign bus.ec   = ec_q;
    assign bus.err  = err_q;

endmodule

// File: tb/tb_up_down_counter.sv
// Bench for up_down_counter: directed scenarios followed by randomized bus
// traffic, all compared against a trajectory-based reference model.
module tb_up_down_counter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    up_down_counter_if bus ();
    wire  [7:0] din;
    logic [7:0] tb_dout;
    logic       tb_oe;
    assign din = tb_oe ? tb_dout : 8'bz;

    up_down_counter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .din (din)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: register file plus the precomputed run trajectory.
    typedef struct packed {
        logic [7:0] v;
        logic       d;
        logic       e;
    } pt_t;

    logic [7:0] m_reg [4];
    logic [7:0] m_cout;
    logic       m_dir;
    logic       m_ec;
    logic       m_err;
    logic       m_run;
    pt_t        m_q [$];

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Whole run as a list of (count, dir, ec) values, one per clock after start.
    task automatic build_run();
        int s, u, l, c;
        s = int'(m_reg[0]);
        u = int'(m_reg[1]);
        l = int'(m_reg[2]);
        c = int'(m_reg[3]);
        m_q.delete();
        m_q.push_back('{v: 8'(s), d: 1'b1, e: 1'b0});
        for (int k = 1; k <= c; k++) begin
            for (int v = s + 1; v <= u; v++)
                m_q.push_back('{v: 8'(v), d: 1'b1, e: 1'b0});
            for (int v = u - 1; v >= l; v--)
                m_q.push_back('{v: 8'(v), d: 1'b0, e: 1'b0});
            for (int v = l + 1; v <= s; v++)
                m_q.push_back('{v: 8'(v), d: 1'b1, e: (k == c) && (v == s)});
        end
    endtask

    task automatic model_edge();
        pt_t pt;
        if (rst) begin
            for (int i = 0; i < 4; i++) m_reg[i] = 8'd0;
            m_cout = 8'd0; m_dir = 1'b0; m_ec = 1'b0; m_err = 1'b0; m_run = 1'b0;
            m_q.delete();
        end else if (bus.ncs) begin
            m_cout = 8'd0; m_dir = 1'b0; m_ec = 1'b0; m_run = 1'b0;
            m_q.delete();
        end else if (m_run) begin
            pt = m_q.pop_front();
            m_cout = pt.v; m_dir = pt.d; m_ec = pt.e;
            if (pt.e || m_q.size() == 0) m_run = 1'b0;
        end else if (bus.start) begin
            if (m_reg[2] < m_reg[0] && m_reg[0] <= m_reg[1] && m_reg[3] != 8'd0) begin
                build_run();
                pt = m_q.pop_front();
                m_cout = pt.v; m_dir = pt.d;
                m_ec = 1'b0; m_err = 1'b0; m_run = 1'b1;
            end else begin
                m_err = 1'b1;
            end
        end else if (!bus.nwr && bus.nrd) begin
            m_reg[{bus.A1, bus.A0}] = tb_dout;
            m_ec = 1'b0; m_err = 1'b0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_val("cout", bus.cout, m_cout);
        check_val("dir", 8'(bus.dir), 8'(m_dir));
        check_val("ec", 8'(bus.ec), 8'(m_ec));
        check_val("err", 8'(bus.err), 8'(m_err));
    endtask

    task automatic bus_idle();
        bus.ncs = 1'b0; bus.nwr = 1'b1; bus.nrd = 1'b1; bus.start = 1'b0;
        tb_oe = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] val);
        {bus.A1, bus.A0} = a;
        bus.nwr = 1'b0; bus.nrd = 1'b1;
        tb_oe = 1'b1; tb_dout = val;
        step();
        bus_idle();
    endtask

    task automatic rd_check(input logic [1:0] a);
        {bus.A1, bus.A0} = a;
        bus.nrd = 1'b0; bus.nwr = 1'b1; tb_oe = 1'b0;
        #1;
        check_val("rd_reg", din, m_reg[a]);
        step();
        bus_idle();
    endtask

    task automatic rd_const(input logic [1:0] a, input logic [7:0] exp);
        {bus.A1, bus.A0} = a;
        bus.nrd = 1'b0; bus.nwr = 1'b1; tb_oe = 1'b0;
        #1;
        check_val("rd_fixed", din, exp);
        step();
        bus_idle();
    endtask

    task automatic start_pulse();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic abort_cycle();
        bus.ncs = 1'b1; bus.nwr = 1'b1; bus.nrd = 1'b1;
        step();
        bus_idle();
    endtask

    logic [7:0] exp_seq [13];
    logic [7:0] exp_dir [13];

    initial begin
        exp_seq = '{8'd4, 8'd5, 8'd6, 8'd5, 8'd4, 8'd3, 8'd4, 8'd5, 8'd6, 8'd5, 8'd4, 8'd3, 8'd4};
        exp_dir = '{8'd1, 8'd1, 8'd1, 8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd0, 8'd0, 8'd0, 8'd1};
        bus.A0 = 1'b0; bus.A1 = 1'b0; tb_dout = 8'd0;
        bus_idle();
        m_cout = 8'd0; m_dir = 1'b0; m_ec = 1'b0; m_err = 1'b0; m_run = 1'b0;
        for (int i = 0; i < 4; i++) m_reg[i] = 8'd0;

        // Reset
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check_val("rst_cout", bus.cout, 8'd0);
        for (int a = 0; a < 4; a++) rd_const(2'(a), 8'd0);

        // Program and read back
        wr(2'b00, 8'd4);
        wr(2'b01, 8'd6);
        wr(2'b10, 8'd3);
        wr(2'b11, 8'd2);
        rd_const(2'b00, 8'd4);
        rd_const(2'b01, 8'd6);
        rd_const(2'b10, 8'd3);
        rd_const(2'b11, 8'd2);

        // Directed run against the literal expected sweep
        bus.start = 1'b1;
        for (int i = 0; i < 13; i++) begin
            step();
            bus.start = 1'b0;
            check_val("seq_cout", bus.cout, exp_seq[i]);
            check_val("seq_dir", 8'(bus.dir), exp_dir[i]);
            check_val("seq_ec", 8'(bus.ec), (i == 12) ? 8'd1 : 8'd0);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            check_val("hold_cout", bus.cout, 8'd4);
            check_val("hold_ec", 8'(bus.ec), 8'd1);
        end

        // Invalid configuration
        wr(2'b10, 8'd5);
        start_pulse();
        check_val("inv_err", 8'(bus.err), 8'd1);
        check_val("inv_cout", bus.cout, 8'd4);
        step();
        step();
        check_val("inv_hold", bus.cout, 8'd4);
        wr(2'b10, 8'd3);
        check_val("inv_clr", 8'(bus.err), 8'd0);

        // Abort by chip deselect
        start_pulse();
        step();
        step();
        step();
        abort_cycle();
        check_val("abort_cout", bus.cout, 8'd0);
        check_val("abort_ec", 8'(bus.ec), 8'd0);
        step();
        check_val("abort_idle", bus.cout, 8'd0);
        rd_const(2'b00, 8'd4);
        rd_const(2'b01, 8'd6);
        rd_const(2'b10, 8'd3);
        rd_const(2'b11, 8'd2);

        // Reset during the down phase
        start_pulse();
        for (int i = 0; i < 20 && m_dir != 1'b0; i++) step();
        check_val("down_phase", 8'(bus.dir), 8'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_val("mid_rst_cout", bus.cout, 8'd0);
        check_val("mid_rst_dir", 8'(bus.dir), 8'd0);
        for (int a = 0; a < 4; a++) rd_const(2'(a), 8'd0);

        // Randomized traffic
        for (int it = 0; it < 30; it++) begin
            int l, u, s, c, n, op;
            if ($urandom % 5 == 0) begin
                for (int a = 0; a < 4; a++) wr(2'(a), 8'($urandom_range(0, 40)));
            end else begin
                l = $urandom_range(0, 200);
                u = l + $urandom_range(1, 20);
                s = $urandom_range(l + 1, u);
                c = $urandom_range(1, 3);
                wr(2'b00, 8'(s));
                wr(2'b01, 8'(u));
                wr(2'b10, 8'(l));
                wr(2'b11, 8'(c));
            end
            start_pulse();
            n = $urandom_range(10, 140);
            for (int k = 0; k < n; k++) begin
                op = $urandom % 16;
                if (op == 10 || op == 11) begin
                    rd_check(2'($urandom % 4));
                end else if (op == 12) begin
                    wr(2'($urandom % 4), 8'($urandom));
                end else if (op == 13) begin
                    start_pulse();
                end else if (op == 14 && ($urandom % 4 == 0)) begin
                    abort_cycle();
                end else begin
                    step();
                end
            end
            if ($urandom % 6 == 0) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
